// File: rtl/yuv422_pkg.sv
// Shared types, field offsets and small helpers for the YUV444 -> YUYV packing path.
package yuv422_pkg;

    typedef enum logic [1:0] {
        S_EVEN = 2'd0,
        S_ODD  = 2'd1,
        S_PAD  = 2'd2
    } state_t;

    localparam int PIX_W  = 24;
    localparam int WORD_W = 32;

    // Input pixel fields {V, U, Y}
    localparam int PIX_Y = 0;
    localparam int PIX_U = 8;
    localparam int PIX_V = 16;

    // Packed output lanes {V, Y1, U, Y0}
    localparam int OUT_Y0 = 0;
    localparam int OUT_U  = 8;
    localparam int OUT_Y1 = 16;
    localparam int OUT_V  = 24;

    typedef struct packed {
        logic             user;
        logic [PIX_W-1:0] pix;
    } held_t;

    // Rounded mean of two 8-bit samples; the 9-bit sum cannot overflow.
    function automatic logic [7:0] avg_round(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b} + 9'd1;
        return sum[8:1];
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

endpackage

// File: rtl/yuv444_to_yuv422.sv
// Two YUV444 pixels -> one YUYV word, registered on cen; output holds while cen is low.
module yuv444_to_yuv422
    import yuv422_pkg::*;
(
    input  logic              clk,
    input  logic              cen,
    input  logic [PIX_W-1:0]  pixel0,
    input  logic [PIX_W-1:0]  pixel1,
    output logic [WORD_W-1:0] word
);

    // NOTE: pure datapath register, no reset; its value is only consumed while the
    // controller's valid flag (which is reset) is high.
    always_ff @(posedge clk) begin
        if (cen) begin
            word[OUT_Y0 +: 8] <= pixel0[PIX_Y +: 8];
            word[OUT_Y1 +: 8] <= pixel1[PIX_Y +: 8];
            word[OUT_U  +: 8] <= avg_round(pixel0[PIX_U +: 8], pixel1[PIX_U +: 8]);
            word[OUT_V  +: 8] <= avg_round(pixel0[PIX_V +: 8], pixel1[PIX_V +: 8]);
        end
    end

endmodule

// File: rtl/yuv422_pack_ctrl.sv
// Pairs YUV444 beats, sequences the yuv444_to_yuv422 converter and presents YUYV words.
// Optional status counters when YUV422_PACK_STATS_EN is defined.
module yuv422_pack_ctrl
    import yuv422_pkg::*;
#(
    parameter int LINE_W_BITS = 11
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tuser,
    input  logic        s_axis_tlast,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tuser,
    output logic        m_axis_tlast,
    output logic        err_odd_line,
    output logic        err_resync
`ifdef YUV422_PACK_STATS_EN
    ,
    output logic [15:0] stat_lines,
    output logic [15:0] stat_odd,
    output logic [15:0] stat_resync
`endif
);

    state_t                 state;
    state_t                 state_next;
    held_t                  hold;
    logic [LINE_W_BITS-1:0] line_cnt;

    logic             out_free;
    logic             beat_acc;
    logic             cen;
    logic             load_hold;
    logic             pad_now;
    logic             resync_now;
    logic [PIX_W-1:0] pix0;
    logic [PIX_W-1:0] pix1;
    logic             word_user;
    logic             word_last;

    assign out_free = !m_axis_tvalid || m_axis_tready;
    assign beat_acc = s_axis_tvalid && s_axis_tready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_EVEN;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves
        // one unassigned and no latch is inferred.
        state_next    = state;
        s_axis_tready = 1'b0;
        cen           = 1'b0;
        load_hold     = 1'b0;
        pad_now       = 1'b0;
        resync_now    = 1'b0;
        pix0          = hold.pix;
        pix1          = s_axis_tdata;
        word_user     = hold.user | s_axis_tuser;
        word_last     = s_axis_tlast;

        unique case (state)
            S_EVEN: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    load_hold  = 1'b1;
                    state_next = s_axis_tlast ? S_PAD : S_ODD;
                end
            end
            S_ODD: begin
                s_axis_tready = out_free;
                if (s_axis_tvalid && out_free) begin
                    if (s_axis_tuser) begin
                        // Mid-pair SOF: the new beat restarts pairing.
                        resync_now = 1'b1;
                        load_hold  = 1'b1;
                        state_next = s_axis_tlast ? S_PAD : S_ODD;
                    end else begin
                        cen        = 1'b1;
                        state_next = S_EVEN;
                    end
                end
            end
            S_PAD: begin
                if (out_free) begin
                    cen        = 1'b1;
                    pad_now    = 1'b1;
                    pix1       = hold.pix;
                    word_user  = hold.user;
                    word_last  = 1'b1;
                    state_next = S_EVEN;
                end
            end
            default: state_next = S_EVEN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold          <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
            err_odd_line  <= 1'b0;
            err_resync    <= 1'b0;
        end else begin
            if (load_hold) begin
                hold.pix  <= s_axis_tdata;
                hold.user <= s_axis_tuser;
            end
            if (cen) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tuser  <= word_user;
                m_axis_tlast  <= word_last;
            end else if (out_free) begin
                m_axis_tvalid <= 1'b0;
            end
            err_odd_line <= pad_now;
            err_resync   <= resync_now;
        end
    end

    // A tuser beat counts as pixel 0 of its line; wrap at 2^LINE_W_BITS is harmless.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_cnt <= '0;
        end else if (beat_acc) begin
            if (s_axis_tlast)      line_cnt <= '0;
            else if (s_axis_tuser) line_cnt <= LINE_W_BITS'(1);
            else                   line_cnt <= line_cnt + 1'b1;
        end
    end

    yuv444_to_yuv422 u_conv (
        .clk    (clk),
        .cen    (cen),
        .pixel0 (pix0),
        .pixel1 (pix1),
        .word   (m_axis_tdata)
    );

`ifdef YUV422_PACK_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_lines  <= '0;
            stat_odd    <= '0;
            stat_resync <= '0;
        end else if (beat_acc && s_axis_tuser) begin
            stat_lines  <= s_axis_tlast ? 16'd1 : 16'd0;
            stat_odd    <= '0;
            stat_resync <= '0;
        end else begin
            if (beat_acc && s_axis_tlast) stat_lines  <= sat_inc(stat_lines);
            if (err_odd_line)             stat_odd    <= sat_inc(stat_odd);
            if (err_resync)               stat_resync <= sat_inc(stat_resync);
        end
    end
`endif

endmodule

// File: doc/yuv422_pack_ctrl.md
Name: yuv422_pack_ctrl

Overview:
- Stream controller that sequences the yuv444_to_yuv422 converter.
- Pairs incoming YUV444 pixels (one per beat) and drives the converter's cen and inputs. Tracks the converter's 1-cycle latency and presents packed YUYV words on an output stream with backpressure.
- Handles odd-length lines by padding and resynchronises on a mid-pair start-of-frame.
- Sits between the palette LUT output and the video output/DMA path.

Parameters:
- LINE_W_BITS, 11, width of the internal pixel-in-line counter; lines up to 2^LINE_W_BITS pixels.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- s_axis_tdata  in  24  input pixel {V[23:16], U[15:8], Y[7:0]}
- s_axis_tvalid  in  1  input beat valid
- s_axis_tready  out  1  input beat accepted when high with tvalid
- s_axis_tuser  in  1  start of frame, on the first pixel of a frame
- s_axis_tlast  in  1  end of line, on the last pixel of a line
- m_axis_tdata  out  32  packed {V[31:24], Y1[23:16], U[15:8], Y0[7:0]}
- m_axis_tvalid  out  1  output word valid
- m_axis_tready  in  1  downstream ready
- m_axis_tuser  out  1  word contains the SOF pixel
- m_axis_tlast  out  1  word contains the EOL pixel
- err_odd_line  out  1  one-cycle pulse: line ended on an even pixel index, padding applied
- err_resync  out  1  one-cycle pulse: SOF arrived while a pixel was held, held pixel dropped

Behaviour:
- Reset (async, rst=1) values:
  - state=S_EVEN; m_axis_tvalid=0; m_axis_tuser=0; m_axis_tlast=0.
  - err_* = 0; hold register cleared; line counter = 0.
  - m_axis_tdata comes from the converter registers and is don't-care while tvalid=0.
- Output slot free: out_free = !m_axis_tvalid || m_axis_tready.
- States:
  - S_EVEN: s_axis_tready=1. An accepted beat is latched into hold (pixel, tuser).
    - tlast=0 -> S_ODD.
    - tlast=1 -> S_PAD.
  - S_ODD: s_axis_tready=out_free.
    - Accepted beat with tuser=1: pulse err_resync, discard hold, latch the new beat as the first of a pair, stay in S_ODD (or go to S_PAD if tlast=1).
    - Accepted beat with tuser=0: assert cen the same cycle. Converter inputs are pixel0=hold, pixel1=s_axis beat. Go to S_EVEN.
  - S_PAD: s_axis_tready=0. When out_free, assert cen with pixel0=pixel1=hold, pulse err_odd_line, go to S_EVEN.
- cen is asserted only in those two cases; it is combinational from state, valid and out_free.
- Latency: the output word is valid the cycle after cen. On cen, m_axis_tvalid<=1, and tuser/tlast are registered alongside:
  - tuser = hold.tuser | beat.tuser
  - tlast = beat.tlast, or 1 for S_PAD.
- When out_free and no cen, m_axis_tvalid<=0.
- Converter output registers hold while cen=0, so data stays stable under backpressure.
- Arithmetic (inside the converter): Y0, Y1 pass through. U=(U0+U1+1)>>1 and V=(V0+V1+1)>>1, 9-bit intermediate, never saturating.
- Line counter: increments per accepted beat. Clears on tlast, and on tuser before that beat is counted. Wraps silently at 2^LINE_W_BITS.
- Simultaneous cen and m_axis_tready: the word is replaced the next cycle; full throughput is 1 word per 2 input beats.
- tuser and tlast on the same beat in S_EVEN: the word is padded and carries both flags.
- Reset mid-pair: the held pixel is lost; no partial word is emitted.

Optional Feature:
- YUV422_PACK_STATS_EN defined: adds outputs stat_lines[15:0], stat_odd[15:0], stat_resync[15:0].
  - Saturating counters of tlast beats, err_odd_line pulses and err_resync pulses.
  - All three clear on rst and on an accepted tuser beat.
- Undefined: the ports and counters are absent, and the error pulses are the only status.

Decomposition:
- Package yuv422_pkg holds:
  - state enum {S_EVEN, S_ODD, S_PAD}
  - byte-lane offsets for the packed word (Y0=0, U=8, Y1=16, V=24)
  - the 24-bit pixel field offsets
- One sub-module: a yuv444_to_yuv422 instance driven by this controller. All sequencing lives in yuv422_pack_ctrl.

Test Plan:
- Pair: beats (Y10,U100,V200), (Y20,U101,V50), tready=1 -> one word Y0=10, U=101, Y1=20, V=125, valid the cycle after the 2nd beat.
- Odd line: 3 beats, tlast on 3rd = (Y30,U7,V9) -> 2nd word Y0=30, U=7, Y1=30, V=9, tlast=1, err_odd_line pulses once.
- Backpressure: tready=0 for 5 cycles with a word pending -> tdata stable, s_axis_tready=0 in S_ODD, no word lost or duplicated after release.
- Resync: beat A, then a tuser beat B, then beat C -> err_resync pulse, A dropped, output word = (B,C) with tuser=1.
- Async reset asserted while in S_ODD with m_axis_tvalid=1 -> m_axis_tvalid=0 immediately; the next 2 beats form a clean word.
- Throughput: 64 beats continuous, tready=1 -> 32 words, with the expected rounded U/V averages checked against a reference model.
